avalon_bus_arbiter: RTL
=======================

# avalon_bus_arbiter

Two-master, one-slave arbiter that shares the single Avalon memory-mapped RAM between the CPU's instruction-fetch master (M0) and data master (M1), or between the CPU and a test loader. It sits between the masters and `RAM_32x64k_avalon`. It forwards one transaction at a time, selects round-robin when both masters request, and holds `waitrequest` high to whichever master is not granted.

## Interface
- `ADDR_W`, 32: address width, passed through unchanged.
- `DATA_W`, 32: data width. Byteenable width is `DATA_W/8`.
- `clk  in  1`: single clock, rising edge.
- `reset  in  1`: synchronous, active-low. Asserted when 0 and sampled on `clk` rising edge.
- `m0_address, m1_address  in  ADDR_W`: master addresses.
- `m0_read, m1_read, m0_write, m1_write  in  1`: master strobes.
- `m0_writedata, m1_writedata  in  DATA_W`: master write data.
- `m0_byteenable, m1_byteenable  in  DATA_W/8`: master byte enables.
- `m0_waitrequest, m1_waitrequest  out  1`: per-master stall.
- `m0_readdata, m1_readdata  out  DATA_W`: per-master read data.
- `s_address  out  ADDR_W`, `s_read, s_write  out  1`, `s_writedata  out  DATA_W`, `s_byteenable  out  DATA_W/8`: slave side.
- `s_waitrequest  in  1`, `s_readdata  in  DATA_W`: slave responses.
- `protocol_error  out  1`: sticky flag. Set when a granted master drops its strobe before completion.

## Operation
- A master requests when `read | write` is high. Asserting both `read` and `write` is illegal; the arbiter forwards both and sets `protocol_error`.
- FSM states are IDLE, GNT0 and GNT1.
- **IDLE:**
  - If only one master requests, go to that master's grant state.
  - If both request, go to the master not equal to `last_grant`.
  - Otherwise stay in IDLE.
- **GNTx:**
  - The slave outputs mirror master x combinationally.
  - `mx_waitrequest = s_waitrequest`.
  - `mx_readdata = s_readdata`.
- **Completion:** a cycle in GNTx with `s_waitrequest == 0` is the completion cycle.
  - `last_grant <= x`.
  - The next state is GNT(other) if the other master requests that cycle, else IDLE.
  - Master x's own request is never re-granted directly, because it is still asserted during its completion cycle.
- **Abort:** in GNTx, if master x drops its strobe while `s_waitrequest == 1`:
  - Go to IDLE.
  - Set `protocol_error`.
  - Slave strobes fall in the same cycle, because they mirror the master.
- **Non-granted master:** `waitrequest = 1` and `readdata = 0`. Any master in IDLE sees `waitrequest = 1`.
- **Idle slave outputs:** `s_read = s_write = 0`, `s_address`, `s_writedata` and `s_byteenable` are 0.
- **Reset:**
  - While `reset == 0`, `s_read` and `s_write` are gated to 0 combinationally.
  - On the sampling edge: state IDLE, `last_grant = 1` (so M0 wins the first tie), `protocol_error = 0`.
- **Reset mid-transaction:** the transaction is abandoned. The slave strobe drops in the cycle `reset` goes low, and no completion is signalled to the master.

## Timing
- **Arbitration latency:** 1 cycle. A request first seen at cycle n appears on the slave at cycle n+1. `mx_waitrequest` is 1 during cycle n.
- **Zero-wait slave:** transaction occupies 2 cycles of master-visible stall plus completion (request cycle n, completion cycle n+1).
- **Handoff:** on completion the other master's transaction starts the next cycle with no idle gap. A sole requester issuing back-to-back gets one IDLE cycle between transactions.
- **`s_readdata`:** forwarded without registering. It is valid to the master only in its completion cycle.
- **Output reset values:**
  - `m0_waitrequest = m1_waitrequest = 1`.
  - `m*_readdata = 0`.
  - All `s_*` outputs 0.
  - `protocol_error = 0`.

## Structure
- The shared package `avalon_pkg` holds:
  - the `arb_state_t` enum {IDLE, GNT0, GNT1};
  - a master-index localparam;
  - the `avalon_req_t` struct (address, read, write, writedata, byteenable), reused by the CPU bus and benches.
- One sub-module, `rr_pick2`, is natural. It is a combinational two-way round-robin selector: inputs `req[1:0]` and `last`, outputs `grant_valid` and `grant_idx`.
- The FSM, `last_grant` register, error flag and muxing live in the top.

## Test plan
- **Single read:** M0 reads 0xBFC00000, RAM holds 0x24020005 with 0 wait states. Required: `s_read` high at cycle n+1, `m0_waitrequest` low at n+1 with `m0_readdata = 0x24020005`, state IDLE at n+2.
- **Simultaneous requests after reset:** M0 reads 0x0, M1 writes 0xDEADBEEF to 0x4 with byteenable 0xF. Required: M0 granted first, M1 granted in the cycle after M0's completion, and reading 0x4 then returns 0xDEADBEEF.
- **Sustained contention:** both masters request continuously for 8 transactions. Required: grants alternate 0,1,0,1…, and neither master waits more than one other transaction.
- **Slave wait states:** RAM holds `waitrequest` for 3 cycles on an M1 write. Required: `m1_waitrequest` mirrors it and `m0_waitrequest` stays 1 throughout.
- **Abort:** M1 drops `read` while `s_waitrequest = 1`. Required: `s_read` falls the same cycle, state IDLE next cycle, `protocol_error = 1` and held until reset.
- **Reset mid-transaction:** `reset` is driven to 0 mid-transaction. Required: `s_read`/`s_write` are 0 in that cycle. After the edge, all outputs are at reset values and `protocol_error = 0`. The next tie is granted to M0.

Source files
------------

// File: rtl/avalon_pkg.sv
// -----------------------------------------------------------------------------
// avalon_pkg
// Shared definitions for the Avalon-MM arbiter, the CPU bus and benches.
//   arb_state_t  : arbiter FSM states (IDLE, GNT0, GNT1)
//   M0_IDX/M1_IDX: master indices used for grant bookkeeping
//   avalon_req_t : one master-side request (address, strobes, data, enables)
//   other_master : returns the index of the opposite master
// -----------------------------------------------------------------------------
package avalon_pkg;

  localparam int AV_ADDR_W = 32;
  localparam int AV_DATA_W = 32;

  localparam logic M0_IDX = 1'b0;
  localparam logic M1_IDX = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [AV_ADDR_W-1:0]   address;
    logic                   read;
    logic                   write;
    logic [AV_DATA_W-1:0]   writedata;
    logic [AV_DATA_W/8-1:0] byteenable;
  } avalon_req_t;

  function automatic logic other_master(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin selector.
//   req[1:0]    in  : request from master 1 / master 0
//   last        in  : index of the master granted most recently
//   grant_valid out : at least one request present
//   grant_idx   out : chosen master (meaningful only when grant_valid)
// -----------------------------------------------------------------------------
module rr_pick2
  import avalon_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);

  assign grant_valid = |req;

  always_comb begin
    grant_idx = M0_IDX;
    if (&req) begin
      // Tie: the master that did not go last wins.
      grant_idx = other_master(last);
    end else if (req[1]) begin
      grant_idx = M1_IDX;
    end
  end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_bus_arbiter
// Shares one Avalon-MM slave between two masters, one transaction at a time,
// round-robin on contention. The non-granted master sees waitrequest=1.
//   clk, reset (sync, active-low)
//   m0_* / m1_*   : master ports (address, read, write, writedata,
//                   byteenable in; waitrequest, readdata out)
//   s_*           : slave port (address, read, write, writedata, byteenable
//                   out; waitrequest, readdata in)
//   protocol_error: sticky; set on abort or on read+write from granted master
// -----------------------------------------------------------------------------
module avalon_bus_arbiter
  import avalon_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,

  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,

  output logic                protocol_error
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic       r_last_grant;
  logic       w_last_grant_next;
  logic       r_protocol_error;
  logic       w_protocol_error_next;

  logic w_req0;
  logic w_req1;
  logic w_grant_valid;
  logic w_grant_idx;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  rr_pick2 u_pick (
    .req         ({w_req1, w_req0}),
    .last        (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  // State register, last-grant memory and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state          <= IDLE;
      r_last_grant     <= M1_IDX;   // M0 wins the first tie
      r_protocol_error <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_last_grant     <= w_last_grant_next;
      r_protocol_error <= w_protocol_error_next;
    end
  end

  // Next-state logic. Completion is checked before abort: a cycle with
  // s_waitrequest low finishes the transaction whatever the master strobes.
  always_comb begin
    w_state_next          = r_state;
    w_last_grant_next     = r_last_grant;
    w_protocol_error_next = r_protocol_error;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_state_next = (w_grant_idx == M1_IDX) ? GNT1 : GNT0;
        end
      end
      GNT0: begin
        if (m0_read && m0_write) begin
          w_protocol_error_next = 1'b1;
        end
        if (!s_waitrequest) begin
          w_last_grant_next = M0_IDX;
          // M0 still holds its strobe here, so it can only be handed off.
          w_state_next      = w_req1 ? GNT1 : IDLE;
        end else if (!w_req0) begin
          w_state_next          = IDLE;
          w_protocol_error_next = 1'b1;
        end
      end
      GNT1: begin
        if (m1_read && m1_write) begin
          w_protocol_error_next = 1'b1;
        end
        if (!s_waitrequest) begin
          w_last_grant_next = M1_IDX;
          w_state_next      = w_req0 ? GNT0 : IDLE;
        end else if (!w_req1) begin
          w_state_next          = IDLE;
          w_protocol_error_next = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath mux. While reset is low everything is forced to its idle value,
  // so an in-flight transaction is dropped in that very cycle and the master
  // never sees a completion.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    if (reset) begin
      case (r_state)
        GNT0: begin
          s_address      = m0_address;
          s_read         = m0_read;
          s_write        = m0_write;
          s_writedata    = m0_writedata;
          s_byteenable   = m0_byteenable;
          m0_waitrequest = s_waitrequest;
          m0_readdata    = s_readdata;
        end
        GNT1: begin
          s_address      = m1_address;
          s_read         = m1_read;
          s_write        = m1_write;
          s_writedata    = m1_writedata;
          s_byteenable   = m1_byteenable;
          m1_waitrequest = s_waitrequest;
          m1_readdata    = s_readdata;
        end
        default: begin
        end
      endcase
    end
  end

  assign protocol_error = r_protocol_error;

endmodule
